// File: rtl/ping_pong_monitor_pkg.sv
// rtl/ping_pong_monitor_pkg.sv - shared encodings for the ping-pong counter and its monitor
//
// Purpose : FSM state encoding of the monitor and the direction constants
//           shared with the ping-pong counter RTL.
// Ports   : none (package).
package ping_pong_monitor_pkg;

    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/ping_pong_monitor_if.sv
// rtl/ping_pong_monitor_if.sv - counter control/observation bundle and monitor results
//
// Purpose : groups the signals seen by the ping-pong monitor.
// Ports   : enable, flip, max, min   - counter controls as driven to the counter
//           direction, out           - observed counter outputs
//           exp_out, exp_dir         - monitor model state
//           mismatch, fault          - divergence pulse and sticky flag
//           bounce_cnt, mismatch_cnt - saturating event counters
//           state                    - monitor FSM state for debug
// Modports: master drives controls/observations, slave is the monitor.
interface ping_pong_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             enable;
    logic             flip;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    logic             direction;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] exp_out;
    logic             exp_dir;
    logic             mismatch;
    logic             fault;
    logic [CNT_W-1:0] bounce_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [1:0]       state;

    modport master (
        output enable, flip, max, min, direction, out,
        input  exp_out, exp_dir, mismatch, fault, bounce_cnt, mismatch_cnt, state
    );

    modport slave (
        input  enable, flip, max, min, direction, out,
        output exp_out, exp_dir, mismatch, fault, bounce_cnt, mismatch_cnt, state
    );
endinterface

// File: rtl/ping_pong_monitor_pp_ref_model.sv
// rtl/ping_pong_monitor_pp_ref_model.sv - combinational next-state function of the ping-pong counter
//
// Purpose : given the current model value/direction and the counter controls,
//           produce the next value/direction and whether a reversal happened.
// Ports   : exp_out, exp_dir            - current model state
//           enable, flip, max, min      - counter controls
//           next_out, next_dir, bounce  - next model state, reversal flag
module pp_ref_model
    import ping_pong_monitor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] exp_out,
    input  logic             exp_dir,
    input  logic             enable,
    input  logic             flip,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    output logic [WIDTH-1:0] next_out,
    output logic             next_dir,
    output logic             bounce
);

    logic active;

    // Range check precedes every step, so unsigned arithmetic never wraps.
    assign active = enable && (max > min) && (exp_out >= min) && (exp_out <= max);

    always_comb begin
        next_out = exp_out;
        next_dir = exp_dir;
        bounce   = 1'b0;
        if (active) begin
            if (flip) begin
                next_dir = ~exp_dir;
                bounce   = 1'b1;
            end else if (exp_dir == DIR_UP && exp_out == max) begin
                next_dir = DIR_DOWN;
                bounce   = 1'b1;
            end else if (exp_dir == DIR_DOWN && exp_out == min) begin
                next_dir = DIR_UP;
                bounce   = 1'b1;
            end
            // A flip taken at a bound can point past it; the count then
            // stays pinned at that bound instead of leaving the range.
            if (next_dir == DIR_UP) begin
                next_out = (exp_out == max) ? max : exp_out + 1'b1;
            end else begin
                next_out = (exp_out == min) ? min : exp_out - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ping_pong_monitor.sv
// rtl/ping_pong_monitor.sv - passive checker comparing a ping-pong counter against a reference model
//
// Purpose : tracks the counter with an independent model, pulses mismatch one
//           cycle after any divergence, keeps a sticky fault flag and
//           saturating bounce/mismatch counters.
// Ports   : clk   - system clock, all state on posedge
//           rst_n - asynchronous active-low reset
//           bus   - ping_pong_monitor_if.slave (controls, observations, results)
module ping_pong_monitor
    import ping_pong_monitor_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 8,
    parameter int RESYNC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    ping_pong_monitor_if.slave bus
);

    mon_state_t       state_q, state_d;
    logic [WIDTH-1:0] exp_out_q, exp_out_d;
    logic             exp_dir_q, exp_dir_d;
    logic             mismatch_q, mismatch_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] bounce_cnt_q, bounce_cnt_d;
    logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;

    logic [WIDTH-1:0] nxt_out;
    logic             nxt_dir;
    logic             nxt_bounce;
    logic             diverge;

    pp_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref_model (
        .exp_out  (exp_out_q),
        .exp_dir  (exp_dir_q),
        .enable   (bus.enable),
        .flip     (bus.flip),
        .max      (bus.max),
        .min      (bus.min),
        .next_out (nxt_out),
        .next_dir (nxt_dir),
        .bounce   (nxt_bounce)
    );

    // In ARMED the model direction is still its reset value (up), so this
    // single compare also covers the "direction must be up" check.
    assign diverge = (bus.out != exp_out_q) || (bus.direction != exp_dir_q);

    always_comb begin
        state_d        = state_q;
        exp_out_d      = exp_out_q;
        exp_dir_d      = exp_dir_q;
        mismatch_d     = 1'b0;
        fault_d        = fault_q;
        bounce_cnt_d   = bounce_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        case (state_q)
            ST_ARMED, ST_TRACK: begin
                if (diverge) begin
                    // Mismatch wins over any bounce; the model holds.
                    mismatch_d = 1'b1;
                    fault_d    = 1'b1;
                    if (mismatch_cnt_q != '1) begin
                        mismatch_cnt_d = mismatch_cnt_q + 1'b1;
                    end
                    state_d = ST_FAULT;
                end else begin
                    exp_out_d = nxt_out;
                    exp_dir_d = nxt_dir;
                    if (nxt_bounce && bounce_cnt_q != '1) begin
                        bounce_cnt_d = bounce_cnt_q + 1'b1;
                    end
                    state_d = ST_TRACK;
                end
            end
            ST_FAULT: begin
                if (RESYNC != 0) begin
                    exp_out_d = bus.out;
                    exp_dir_d = bus.direction;
                    state_d   = ST_TRACK;
                end
            end
            default: begin
                state_d = ST_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_ARMED;
            exp_out_q      <= bus.min;
            exp_dir_q      <= DIR_UP;
            mismatch_q     <= 1'b0;
            fault_q        <= 1'b0;
            bounce_cnt_q   <= '0;
            mismatch_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            exp_out_q      <= exp_out_d;
            exp_dir_q      <= exp_dir_d;
            mismatch_q     <= mismatch_d;
            fault_q        <= fault_d;
            bounce_cnt_q   <= bounce_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
        end
    end

    assign bus.exp_out      = exp_out_q;
    assign bus.exp_dir      = exp_dir_q;
    assign bus.mismatch     = mismatch_q;
    assign bus.fault        = fault_q;
    assign bus.bounce_cnt   = bounce_cnt_q;
    assign bus.mismatch_cnt = mismatch_cnt_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_ping_pong_monitor.sv
// tb/tb_ping_pong_monitor.sv - self-checking bench for ping_pong_monitor (RESYNC=1 and RESYNC=0)
module tb_ping_pong_monitor;

    localparam int S_ARMED = 0;
    localparam int S_TRACK = 1;
    localparam int S_FAULT = 2;
    localparam int CNT_MAX = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ping_pong_monitor_if #(.WIDTH(4), .CNT_W(8)) if0 ();
    ping_pong_monitor_if #(.WIDTH(4), .CNT_W(8)) if1 ();

    ping_pong_monitor #(.WIDTH(4), .CNT_W(8), .RESYNC(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );
    ping_pong_monitor #(.WIDTH(4), .CNT_W(8), .RESYNC(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // stimulus values shared by both monitors
    int en, fl, mx, mn, obs_out, obs_dir;
    // bench-side counter (the thing being monitored)
    int ctr_out, ctr_dir;
    // expected monitor state, index 0 = RESYNC 0, 1 = RESYNC 1
    int m_out[2], m_dir[2], m_st[2], m_mis[2], m_flt[2], m_bc[2], m_mc[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // counter contract, written with plain integer arithmetic
    task automatic ref_next(input int o, input int d, output int no, output int nd, output int bn);
        no = o; nd = d; bn = 0;
        if (en != 0 && mx > mn && o >= mn && o <= mx) begin
            if (fl != 0) begin
                nd = 1 - d; bn = 1;
            end else if (d == 1 && o == mx) begin
                nd = 0; bn = 1;
            end else if (d == 0 && o == mn) begin
                nd = 1; bn = 1;
            end
            if (nd == 1) no = (o < mx) ? o + 1 : mx;
            else         no = (o > mn) ? o - 1 : mn;
        end
    endtask

    task automatic apply();
        if0.enable = en[0];  if1.enable = en[0];
        if0.flip = fl[0];    if1.flip = fl[0];
        if0.max = mx[3:0];   if1.max = mx[3:0];
        if0.min = mn[3:0];   if1.min = mn[3:0];
        if0.out = obs_out[3:0];   if1.out = obs_out[3:0];
        if0.direction = obs_dir[0]; if1.direction = obs_dir[0];
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = mn; m_dir[k] = 1; m_st[k] = S_ARMED;
            m_mis[k] = 0; m_flt[k] = 0; m_bc[k] = 0; m_mc[k] = 0;
        end
        ctr_out = mn; ctr_dir = 1;
    endtask

    task automatic mon_update(input int k);
        int no, nd, bn;
        m_mis[k] = 0;
        if (m_st[k] == S_FAULT) begin
            if (k == 1) begin
                m_out[k] = obs_out; m_dir[k] = obs_dir; m_st[k] = S_TRACK;
            end
        end else if (obs_out != m_out[k] || obs_dir != m_dir[k]) begin
            m_mis[k] = 1; m_flt[k] = 1; m_st[k] = S_FAULT;
            if (m_mc[k] < CNT_MAX) m_mc[k]++;
        end else begin
            ref_next(m_out[k], m_dir[k], no, nd, bn);
            m_out[k] = no; m_dir[k] = nd; m_st[k] = S_TRACK;
            if (bn != 0 && m_bc[k] < CNT_MAX) m_bc[k]++;
        end
    endtask

    task automatic check_dut(input int k);
        chk($sformatf("r%0d_exp_out", k),  k ? if1.exp_out : if0.exp_out, m_out[k]);
        chk($sformatf("r%0d_exp_dir", k),  k ? if1.exp_dir : if0.exp_dir, m_dir[k]);
        chk($sformatf("r%0d_mismatch", k), k ? if1.mismatch : if0.mismatch, m_mis[k]);
        chk($sformatf("r%0d_fault", k),    k ? if1.fault : if0.fault, m_flt[k]);
        chk($sformatf("r%0d_bounce_cnt", k), k ? if1.bounce_cnt : if0.bounce_cnt, m_bc[k]);
        chk($sformatf("r%0d_mismatch_cnt", k), k ? if1.mismatch_cnt : if0.mismatch_cnt, m_mc[k]);
        chk($sformatf("r%0d_state", k),    k ? if1.state : if0.state, m_st[k]);
    endtask

    task automatic step(input bit corrupt, input int cval);
        int no, nd, bn;
        obs_out = corrupt ? cval : ctr_out;
        obs_dir = ctr_dir;
        apply();
        @(posedge clk);
        mon_update(0);
        mon_update(1);
        ref_next(ctr_out, ctr_dir, no, nd, bn);
        ctr_out = no; ctr_dir = nd;
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_exp_out0"}, if0.exp_out, mn);
        chk({tag, "_exp_out1"}, if1.exp_out, mn);
        chk({tag, "_exp_dir"}, {if0.exp_dir, if1.exp_dir}, 2'b11);
        chk({tag, "_mismatch"}, {if0.mismatch, if1.mismatch}, 2'b00);
        chk({tag, "_fault"}, {if0.fault, if1.fault}, 2'b00);
        chk({tag, "_cnts"}, {if0.bounce_cnt, if0.mismatch_cnt, if1.bounce_cnt, if1.mismatch_cnt}, 32'd0);
        chk({tag, "_state"}, {if0.state, if1.state}, {2'(S_ARMED), 2'(S_ARMED)});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        obs_out = ctr_out; obs_dir = ctr_dir;
        apply();
        @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
    endtask

    int seq_exp[12] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4};
    int held, b0, guard;

    initial begin
        en = 1; fl = 0; mx = 4; mn = 0;
        do_reset();

        // basic bounce sequence
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 0);
            chk($sformatf("seq_exp_out_%0d", i), if1.exp_out, seq_exp[i]);
        end
        chk("seq_bounce_cnt", if1.bounce_cnt, 2);
        chk("seq_fault", if1.fault, 0);

        // flip at out = 2 going up
        guard = 0;
        while (!(ctr_out == 2 && ctr_dir == 1) && guard < 20) begin
            step(1'b0, 0);
            guard++;
        end
        chk("flip_reach_timeout", guard < 20, 1);
        b0 = m_bc[1];
        fl = 1;
        step(1'b0, 0);
        fl = 0;
        chk("flip_exp_out", if1.exp_out, 1);
        chk("flip_exp_dir", if1.exp_dir, 0);
        chk("flip_bounce", if1.bounce_cnt, b0 + 1);
        chk("flip_mismatch", if1.mismatch, 0);

        // disabled, then inverted bounds: model holds
        held = ctr_out;
        en = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 0);
        chk("hold_disabled", if1.exp_out, held);
        en = 1; mx = 1; mn = 4;
        for (int i = 0; i < 5; i++) step(1'b0, 0);
        chk("hold_inverted", if1.exp_out, held);
        chk("hold_no_fault", {if0.fault, if1.fault}, 2'b00);
        mx = 4; mn = 0;

        // corruption at out = 3
        guard = 0;
        while (ctr_out != 3 && guard < 20) begin
            step(1'b0, 0);
            guard++;
        end
        chk("inj_reach_timeout", guard < 20, 1);
        en = 0;
        step(1'b0, 0);
        step(1'b1, 7);
        chk("inj_mismatch", {if0.mismatch, if1.mismatch}, 2'b11);
        chk("inj_mismatch_cnt1", if1.mismatch_cnt, 1);
        chk("inj_fault", {if0.fault, if1.fault}, 2'b11);
        step(1'b0, 0);
        chk("inj_resync_state", if1.state, S_TRACK);
        chk("inj_hold_state", if0.state, S_FAULT);
        chk("inj_pulse_width", {if0.mismatch, if1.mismatch}, 2'b00);
        step(1'b1, 7);
        step(1'b1, 9);
        chk("inj_r0_cnt_stays", if0.mismatch_cnt, 1);
        chk("inj_r0_no_pulse", if0.mismatch, 0);

        // asynchronous reset mid-count at out = 3
        en = 1; mx = 4; mn = 0;
        guard = 0;
        do begin
            step(1'b0, 0);
            guard++;
        end while (ctr_out != 3 && guard < 20);
        chk("arst_reach_timeout", guard < 20, 1);
        rst_n = 1'b0;
        #2;
        check_reset_vals("arst");
        model_reset();
        obs_out = ctr_out; obs_dir = ctr_dir;
        apply();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // randomized run against the model
        for (int i = 0; i < 500; i++) begin
            en = ($urandom_range(7) != 0) ? 1 : 0;
            fl = ($urandom_range(9) == 0) ? 1 : 0;
            if ($urandom_range(39) == 0) begin
                mx = $urandom_range(15);
                mn = $urandom_range(15);
            end else if ($urandom_range(59) == 0) begin
                mx = 15; mn = 0;
            end
            if ($urandom_range(199) == 0) begin
                do_reset();
            end else if ($urandom_range(24) == 0) begin
                step(1'b1, ctr_out ^ $urandom_range(15, 1));
            end else begin
                step(1'b0, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
